// File: rtl/sat_pkg.sv
// rtl/sat_pkg.sv - shared solver types and default sizing
package sat_pkg;

   localparam int NUM_VARIABLE   = 128;
   localparam int VARIABLE_INDEX = 6;

   typedef logic [VARIABLE_INDEX:0] var_idx_t;

   // "var" is a reserved word, so the index field is named vidx
   typedef struct packed {
      var_idx_t vidx;
      logic     value;
   } implication_t;

endpackage

// File: rtl/implication_fifo.sv
// rtl/implication_fifo.sv - synchronous FIFO with a registered head entry
module implication_fifo
   import sat_pkg::*;
#(
   parameter int  DEPTH   = 8,
   parameter type entry_t = implication_t
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   push,
   input  entry_t                 din,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output entry_t                 head
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);
   localparam logic [PW:0] ONE_COUNT  = (PW + 1)'(1);

   entry_t            mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     rd_next;
   logic [PW:0]       count_q, count_d;
   entry_t            head_q, head_d;
   logic              push_ok, pop_ok;

   assign full    = (count_q == FULL_COUNT);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = head_q;
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_next = rd_ptr_q + 1'b1;

   // Next pointers, occupancy and head; the head register is refilled from
   // the incoming entry when the queue is (or is about to become) empty,
   // otherwise from the slot behind the current head.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         head_d   = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_d = rd_next;
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         if (push_ok && (empty || (pop_ok && count_q == ONE_COUNT))) begin
            head_d = din;
         end else if (pop_ok && count_q > ONE_COUNT) begin
            head_d = mem_q[rd_next];
         end
      end
   end

   // Control state with asynchronous reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   // Storage array; contents are only meaningful between rd and wr pointers
   always_ff @(posedge clock) begin
      if (push_ok && !flush) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/implication_queue.sv
// rtl/implication_queue.sv - dedup/conflict-checking queue of implications
module implication_queue #(
   parameter int NUM_VARIABLE   = sat_pkg::NUM_VARIABLE,
   parameter int VARIABLE_INDEX = sat_pkg::VARIABLE_INDEX,
   parameter int DEPTH          = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   input  logic [VARIABLE_INDEX:0]   in_var,
   input  logic                      in_value,
   output logic                      in_ready,
   output logic                      out_valid,
   output logic [VARIABLE_INDEX:0]   out_var,
   output logic                      out_value,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      conflict,
   output logic [VARIABLE_INDEX:0]   conflict_var
);

   typedef struct packed {
      logic [VARIABLE_INDEX:0] vidx;
      logic                    value;
   } entry_t;

   logic [NUM_VARIABLE-1:0] pend_q, pend_d;
   logic [NUM_VARIABLE-1:0] pend_val_q, pend_val_d;
   logic                    conflict_q, conflict_d;
   logic [VARIABLE_INDEX:0] conflict_var_q, conflict_var_d;

   logic                    fifo_full, fifo_empty;
   logic [$clog2(DEPTH):0]  fifo_count;
   entry_t                  fifo_head;
   entry_t                  fifo_din;

   logic                    push_fire, pop_fire;
   logic                    is_pend, same_val;
   logic                    enq, conflict_now;

   assign in_ready     = !fifo_full && !conflict_q;
   assign out_valid    = !fifo_empty;
   assign out_var      = fifo_head.vidx;
   assign out_value    = fifo_head.value;
   assign count        = fifo_count;
   assign conflict     = conflict_q;
   assign conflict_var = conflict_var_q;

   assign push_fire    = in_valid && in_ready;
   assign pop_fire     = out_valid && out_ready;

   // Pending lookup uses pre-edge state, so an entry popping this cycle
   // still shadows a same-variable push.
   assign is_pend      = pend_q[in_var];
   assign same_val     = (pend_val_q[in_var] == in_value);
   assign enq          = push_fire && !is_pend;
   assign conflict_now = push_fire && is_pend && !same_val;

   assign fifo_din.vidx  = in_var;
   assign fifo_din.value = in_value;

   implication_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .push  (enq),
      .din   (fifo_din),
      .pop   (pop_fire),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count),
      .head  (fifo_head)
   );

   // Pending bitmap and sticky conflict next-state; an enqueued variable is
   // never pending, so its set cannot collide with the popped head's clear.
   always_comb begin
      pend_d         = pend_q;
      pend_val_d     = pend_val_q;
      conflict_d     = conflict_q;
      conflict_var_d = conflict_var_q;
      if (flush) begin
         pend_d         = '0;
         pend_val_d     = '0;
         conflict_d     = 1'b0;
         conflict_var_d = '0;
      end else begin
         if (pop_fire) begin
            pend_d[fifo_head.vidx] = 1'b0;
         end
         if (enq) begin
            pend_d[in_var]     = 1'b1;
            pend_val_d[in_var] = in_value;
         end
         if (conflict_now && !conflict_q) begin
            conflict_d     = 1'b1;
            conflict_var_d = in_var;
         end
      end
   end

   // Pending and conflict registers with asynchronous reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pend_q         <= '0;
         pend_val_q     <= '0;
         conflict_q     <= 1'b0;
         conflict_var_q <= '0;
      end else begin
         pend_q         <= pend_d;
         pend_val_q     <= pend_val_d;
         conflict_q     <= conflict_d;
         conflict_var_q <= conflict_var_d;
      end
   end

endmodule

// File: tb/tb_implication_queue.sv
// tb/tb_implication_queue.sv - directed self-checking bench for implication_queue
module tb_implication_queue;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic [6:0] in_var = '0;
   logic       in_value = 1'b0;
   logic       in_ready;
   logic       out_valid;
   logic [6:0] out_var;
   logic       out_value;
   logic       out_ready = 1'b0;
   logic [3:0] count;
   logic       conflict;
   logic [6:0] conflict_var;

   int checks   = 0;
   int failures = 0;

   int ord_var [3] = '{5, 9, 17};
   int ord_val [3] = '{1, 0, 1};

   implication_queue #(
      .NUM_VARIABLE   (128),
      .VARIABLE_INDEX (6),
      .DEPTH          (8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_var       (in_var),
      .in_value     (in_value),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_var      (out_var),
      .out_value    (out_value),
      .out_ready    (out_ready),
      .count        (count),
      .conflict     (conflict),
      .conflict_var (conflict_var)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic push(input int v, input int val);
      in_valid = 1'b1;
      in_var   = 7'(v);
      in_value = val[0];
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("rst_count", count, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_conflict", conflict, 0);
      check("rst_conflict_var", conflict_var, 0);
      check("rst_out_var", out_var, 0);
      check("rst_out_value", out_value, 0);

      // asynchronous reset with three entries queued
      push(1, 1);
      push(2, 0);
      push(3, 1);
      check("pre_rst_count", count, 3);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_count", count, 0);
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_conflict", conflict, 0);
      tick();
      reset = 1'b0;
      tick();
      check("post_rst_in_ready", in_ready, 1);

      // ordering and one-cycle latency
      push(5, 1);
      check("lat_out_valid", out_valid, 1);
      check("lat_out_var", out_var, 5);
      check("lat_out_value", out_value, 1);
      push(9, 0);
      push(17, 1);
      check("ord_count", count, 3);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("ord_var", out_var, ord_var[i]);
         check("ord_val", out_value, ord_val[i]);
         check("ord_cnt", count, 3 - i);
         tick();
      end
      out_ready = 1'b0;
      check("ord_end_count", count, 0);
      check("ord_end_valid", out_valid, 0);

      // dedup, including a same-value push while that entry pops
      push(12, 1);
      push(12, 1);
      check("dup_count", count, 1);
      check("dup_var", out_var, 12);
      in_valid = 1'b1; in_var = 7'd12; in_value = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      check("dup_pop_count", count, 0);
      check("dup_pop_valid", out_valid, 0);
      check("dup_pop_conflict", conflict, 0);
      push(12, 1);
      check("dup_repush_count", count, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("dup_drain_count", count, 0);

      // conflict
      push(40, 1);
      push(40, 0);
      check("cf_conflict", conflict, 1);
      check("cf_var", conflict_var, 40);
      check("cf_in_ready", in_ready, 0);
      check("cf_count", count, 1);
      check("cf_head_var", out_var, 40);
      check("cf_head_val", out_value, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("cf_drain_count", count, 0);
      check("cf_sticky", conflict, 1);
      in_valid = 1'b1; in_var = 7'd41; in_value = 1'b0;
      check("cf_refuse_ready", in_ready, 0);
      tick();
      in_valid = 1'b0;
      check("cf_refuse_count", count, 0);
      check("cf_var_hold", conflict_var, 40);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("cf_flush_conflict", conflict, 0);
      check("cf_flush_var", conflict_var, 0);
      check("cf_flush_count", count, 0);
      check("cf_flush_ready", in_ready, 1);

      // full, refused push at full with pop, then wrap
      for (int i = 0; i < 8; i++) push(60 + i, i & 1);
      check("full_count", count, 8);
      check("full_in_ready", in_ready, 0);
      in_valid = 1'b1; in_var = 7'd70; in_value = 1'b1; out_ready = 1'b1;
      tick();
      check("full_pop_count", count, 7);
      check("full_pop_head", out_var, 61);
      for (int k = 0; k < 20; k++) begin
         in_var   = 7'(80 + k);
         in_value = k[0];
         check("wrap_ready", in_ready, 1);
         if (k < 7) begin
            check("wrap_var", out_var, 61 + k);
            check("wrap_val", out_value, (1 + k) & 1);
         end else begin
            check("wrap_var", out_var, 80 + k - 7);
            check("wrap_val", out_value, (k - 7) & 1);
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("wrap_count", count, 7);
      out_ready = 1'b1;
      for (int j = 13; j < 20; j++) begin
         check("tail_var", out_var, 80 + j);
         check("tail_val", out_value, j & 1);
         tick();
      end
      out_ready = 1'b0;
      check("tail_count", count, 0);

      // flush beats a simultaneous push and pop
      push(2, 0);
      in_valid = 1'b1; in_var = 7'd3; in_value = 1'b1; out_ready = 1'b1; flush = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      check("fl_count", count, 0);
      check("fl_valid", out_valid, 0);
      check("fl_out_var", out_var, 0);
      push(3, 0);
      check("fl_repush_conflict", conflict, 0);
      check("fl_repush_count", count, 1);
      check("fl_repush_var", out_var, 3);
      check("fl_repush_val", out_value, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
